// File: rtl/mem_port_arbiter.sv
// Shared physical-memory responder for the fetch and load/store ports.
// Serves every request pending at round start, then answers all at once.
module mem_port_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_read,
  input  logic [31:0] instr_mem_address,
  output logic        instr_mem_resp,
  output logic [31:0] instr_mem_rdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_wdata,
  input  logic [3:0]  data_mbe,
  output logic        data_mem_resp,
  output logic [31:0] data_mem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [31:0] pmem_address,
  output logic [31:0] pmem_wdata,
  output logic [3:0]  pmem_mbe,
  input  logic [31:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    SECOND,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic        pend_d_q, pend_i_q, wr_q;
  logic [31:0] i_addr_q, d_addr_q, wdata_q;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic [3:0]  mbe_q;

  logic req_d, req_any;
  logic busy, in_resp, serve_d;

  assign req_d   = data_read | data_write;
  assign req_any = req_d | instr_read;
  assign busy    = (state_q == FIRST) || (state_q == SECOND);
  assign in_resp = (state_q == RESP);

  // SECOND only exists when both ports are pending, so it
  // always serves whichever port FIRST skipped.
  always_comb begin
    serve_d = 1'b0;
    unique case (1'b1)
      (state_q == FIRST):
        serve_d = DATA_FIRST ? pend_d_q : !pend_i_q;
      (state_q == SECOND):
        serve_d = !DATA_FIRST;
      default:
        serve_d = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_any) state_d = FIRST;
      end
      FIRST: begin
        if (pmem_resp)
          state_d = (pend_d_q && pend_i_q) ? SECOND : RESP;
      end
      SECOND: begin
        if (pmem_resp) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    pmem_mbe     = '0;
    if (busy) begin
      if (serve_d) begin
        pmem_read    = !wr_q;
        pmem_write   = wr_q;
        pmem_address = d_addr_q;
        pmem_wdata   = wdata_q;
        pmem_mbe     = mbe_q;
      end else begin
        pmem_read    = 1'b1;
        pmem_address = i_addr_q;
      end
    end
  end

  assign instr_mem_resp  = in_resp & pend_i_q;
  assign data_mem_resp   = in_resp & pend_d_q;
  assign instr_mem_rdata = in_resp ? i_rdata_q : '0;
  assign data_mem_rdata  = in_resp ? d_rdata_q : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      pend_d_q  <= 1'b0;
      pend_i_q  <= 1'b0;
      wr_q      <= 1'b0;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      wdata_q   <= '0;
      mbe_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_any) begin
        pend_d_q <= req_d;
        pend_i_q <= instr_read;
        wr_q     <= data_write;
        i_addr_q <= instr_mem_address;
        d_addr_q <= data_mem_address;
        wdata_q  <= data_mem_wdata;
        mbe_q    <= data_mbe;
      end
      if (busy && pmem_resp) begin
        if (serve_d)
          d_rdata_q <= wr_q ? 32'h0 : pmem_rdata;
        else
          i_rdata_q <= pmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario.
// A second instance covers the instruction-first ordering.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_read;
  logic [31:0] instr_mem_address;
  logic        data_read, data_write;
  logic [31:0] data_mem_address, data_mem_wdata;
  logic [3:0]  data_mbe;
  logic [31:0] pmem_rdata;
  logic        pmem_resp;
  logic [31:0] b_pmem_rdata;
  logic        b_pmem_resp;

  logic        instr_mem_resp, data_mem_resp;
  logic [31:0] instr_mem_rdata, data_mem_rdata;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address, pmem_wdata;
  logic [3:0]  pmem_mbe;

  logic        b_instr_resp, b_data_resp;
  logic [31:0] b_instr_rdata, b_data_rdata;
  logic        b_pmem_read, b_pmem_write;
  logic [31:0] b_pmem_address, b_pmem_wdata;
  logic [3:0]  b_pmem_mbe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .instr_read(instr_read),
    .instr_mem_address(instr_mem_address),
    .instr_mem_resp(instr_mem_resp),
    .instr_mem_rdata(instr_mem_rdata),
    .data_read(data_read), .data_write(data_write),
    .data_mem_address(data_mem_address),
    .data_mem_wdata(data_mem_wdata),
    .data_mbe(data_mbe),
    .data_mem_resp(data_mem_resp),
    .data_mem_rdata(data_mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_mbe(pmem_mbe),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  mem_port_arbiter #(.DATA_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .instr_read(instr_read),
    .instr_mem_address(instr_mem_address),
    .instr_mem_resp(b_instr_resp),
    .instr_mem_rdata(b_instr_rdata),
    .data_read(data_read), .data_write(data_write),
    .data_mem_address(data_mem_address),
    .data_mem_wdata(data_mem_wdata),
    .data_mbe(data_mbe),
    .data_mem_resp(b_data_resp),
    .data_mem_rdata(b_data_rdata),
    .pmem_read(b_pmem_read), .pmem_write(b_pmem_write),
    .pmem_address(b_pmem_address),
    .pmem_wdata(b_pmem_wdata), .pmem_mbe(b_pmem_mbe),
    .pmem_rdata(b_pmem_rdata), .pmem_resp(b_pmem_resp)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    instr_read        = 1'b0;
    instr_mem_address = '0;
    data_read         = 1'b0;
    data_write        = 1'b0;
    data_mem_address  = '0;
    data_mem_wdata    = '0;
    data_mbe          = '0;
    pmem_rdata        = '0;
    pmem_resp         = 1'b0;
    b_pmem_rdata      = '0;
    b_pmem_resp       = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    checks++;
    if ({pmem_read, pmem_write, pmem_mbe} !== 6'h0) begin
      errors++;
      $display("FAIL reset_pmem_ctl got %b want 0",
               {pmem_read, pmem_write, pmem_mbe});
    end
    checks++;
    if ({pmem_address, pmem_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_pmem_bus got %h want 0",
               {pmem_address, pmem_wdata});
    end
    checks++;
    if ({instr_mem_resp, data_mem_resp, instr_mem_rdata,
         data_mem_rdata} !== 66'h0) begin
      errors++;
      $display("FAIL reset_resp got %b/%b want 0",
               instr_mem_resp, data_mem_resp);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch_only;
    instr_read        = 1'b1;
    instr_mem_address = 32'h60;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({pmem_read, pmem_write, pmem_address} !==
          {2'b10, 32'h60}) begin
        errors++;
        $display("FAIL fetch_pmem c%0d got r%b w%b a%h want r1 w0 a60",
                 c, pmem_read, pmem_write, pmem_address);
      end
      checks++;
      if (instr_mem_resp !== 1'b0) begin
        errors++;
        $display("FAIL fetch_early_resp c%0d got %b want 0",
                 c, instr_mem_resp);
      end
      if (c == 2) begin
        pmem_resp  = 1'b1;
        pmem_rdata = 32'h00A00093;
      end
    end
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    checks++;
    if ({instr_mem_resp, instr_mem_rdata} !== {1'b1, 32'h00A00093}) begin
      errors++;
      $display("FAIL fetch_resp got %b %h want 1 00a00093",
               instr_mem_resp, instr_mem_rdata);
    end
    checks++;
    if ({data_mem_resp, pmem_read} !== 2'b00) begin
      errors++;
      $display("FAIL fetch_other got d%b r%b want 0 0",
               data_mem_resp, pmem_read);
    end
    instr_read = 1'b0;
    tick();
    checks++;
    if ({instr_mem_resp, instr_mem_rdata} !== 33'h0) begin
      errors++;
      $display("FAIL fetch_pulse got %b %h want 0 0",
               instr_mem_resp, instr_mem_rdata);
    end
  endtask

  task automatic test_fetch_load;
    instr_read        = 1'b1;
    instr_mem_address = 32'h64;
    data_read         = 1'b1;
    data_mem_address  = 32'h100;
    tick();
    checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL both_slot1 got r%b a%h want r1 a100",
               pmem_read, pmem_address);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hDEADBEEF;
    tick();
    checks++;
    if ({pmem_read, pmem_address, instr_mem_resp, data_mem_resp} !==
        {1'b1, 32'h64, 2'b00}) begin
      errors++;
      $display("FAIL both_slot2 got r%b a%h want r1 a64 no resp",
               pmem_read, pmem_address);
    end
    pmem_rdata = 32'h12345678;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    checks++;
    if ({instr_mem_resp, data_mem_resp} !== 2'b11) begin
      errors++;
      $display("FAIL both_resp got i%b d%b want 1 1",
               instr_mem_resp, data_mem_resp);
    end
    checks++;
    if ({data_mem_rdata, instr_mem_rdata} !==
        {32'hDEADBEEF, 32'h12345678}) begin
      errors++;
      $display("FAIL both_rdata got %h %h want deadbeef 12345678",
               data_mem_rdata, instr_mem_rdata);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_store;
    data_write       = 1'b1;
    data_mem_address = 32'h200;
    data_mem_wdata   = 32'h0000AB00;
    data_mbe         = 4'b0010;
    tick();
    checks++;
    if ({pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_mbe} !==
        {2'b01, 32'h200, 32'h0000AB00, 4'b0010}) begin
      errors++;
      $display("FAIL store_pmem got r%b w%b a%h d%h m%b",
               pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_mbe);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hFFFFFFFF;
    tick();
    pmem_resp = 1'b0;
    checks++;
    if ({data_mem_resp, data_mem_rdata, instr_mem_resp} !==
        {1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL store_resp got %b %h i%b want 1 0 0",
               data_mem_resp, data_mem_rdata, instr_mem_resp);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_rw_both;
    data_read        = 1'b1;
    data_write       = 1'b1;
    data_mem_address = 32'h300;
    data_mem_wdata   = 32'h11223344;
    data_mbe         = 4'b1111;
    tick();
    checks++;
    if ({pmem_read, pmem_write, pmem_wdata} !==
        {2'b01, 32'h11223344}) begin
      errors++;
      $display("FAIL rw_pmem got r%b w%b d%h want r0 w1 d11223344",
               pmem_read, pmem_write, pmem_wdata);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = 32'h55555555;
    tick();
    pmem_resp = 1'b0;
    checks++;
    if ({data_mem_resp, data_mem_rdata} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL rw_resp got %b %h want 1 0",
               data_mem_resp, data_mem_rdata);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_mid_change;
    instr_read        = 1'b1;
    instr_mem_address = 32'h80;
    tick();
    instr_mem_address = 32'h90;
    data_read         = 1'b1;
    data_mem_address  = 32'h400;
    tick();
    checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 32'h80}) begin
      errors++;
      $display("FAIL mid_addr got r%b a%h want r1 a80",
               pmem_read, pmem_address);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hCAFE0001;
    tick();
    pmem_resp = 1'b0;
    checks++;
    if ({instr_mem_resp, instr_mem_rdata, data_mem_resp} !==
        {1'b1, 32'hCAFE0001, 1'b0}) begin
      errors++;
      $display("FAIL mid_resp got i%b %h d%b want 1 cafe0001 0",
               instr_mem_resp, instr_mem_rdata, data_mem_resp);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_spurious;
    pmem_resp  = 1'b1;
    pmem_rdata = 32'hBAD0BAD0;
    tick();
    pmem_resp = 1'b0;
    checks++;
    if ({pmem_read, pmem_write, instr_mem_resp, data_mem_resp} !==
        4'b0000) begin
      errors++;
      $display("FAIL spur_idle got r%b w%b i%b d%b want 0",
               pmem_read, pmem_write, instr_mem_resp, data_mem_resp);
    end
    instr_read        = 1'b1;
    instr_mem_address = 32'h40;
    tick();
    checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 32'h40}) begin
      errors++;
      $display("FAIL spur_next got r%b a%h want r1 a40",
               pmem_read, pmem_address);
    end
    pmem_resp  = 1'b1;
    pmem_rdata = 32'h00000013;
    tick();
    instr_read = 1'b0;
    pmem_rdata = 32'hBAD0BAD0;
    checks++;
    if ({instr_mem_resp, instr_mem_rdata} !== {1'b1, 32'h13}) begin
      errors++;
      $display("FAIL spur_resp got %b %h want 1 13",
               instr_mem_resp, instr_mem_rdata);
    end
    tick();
    pmem_resp = 1'b0;
    checks++;
    if ({pmem_read, instr_mem_resp, instr_mem_rdata} !== 34'h0) begin
      errors++;
      $display("FAIL spur_resp_state got r%b i%b %h want 0",
               pmem_read, instr_mem_resp, instr_mem_rdata);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid;
    instr_read        = 1'b1;
    instr_mem_address = 32'h64;
    data_read         = 1'b1;
    data_mem_address  = 32'h100;
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = 32'h0BADF00D;
    tick();
    pmem_resp = 1'b0;
    checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 32'h64}) begin
      errors++;
      $display("FAIL rstmid_second got r%b a%h want r1 a64",
               pmem_read, pmem_address);
    end
    rst = 1'b0;
    clear_inputs();
    tick();
    checks++;
    if ({pmem_read, pmem_write, pmem_address, instr_mem_resp,
         data_mem_resp, data_mem_rdata} !== 68'h0) begin
      errors++;
      $display("FAIL rstmid_out got r%b a%h i%b d%b want 0",
               pmem_read, pmem_address, instr_mem_resp, data_mem_resp);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({pmem_read, instr_mem_resp, data_mem_resp} !== 3'b000) begin
      errors++;
      $display("FAIL rstmid_idle got r%b i%b d%b want 0",
               pmem_read, instr_mem_resp, data_mem_resp);
    end
    instr_read        = 1'b1;
    instr_mem_address = 32'h44;
    tick();
    checks++;
    if ({pmem_read, pmem_address} !== {1'b1, 32'h44}) begin
      errors++;
      $display("FAIL rstmid_restart got r%b a%h want r1 a44",
               pmem_read, pmem_address);
    end
    pmem_resp = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_instr_first;
    rst = 1'b0;
    clear_inputs();
    tick();
    rst = 1'b1;
    instr_read        = 1'b1;
    instr_mem_address = 32'h64;
    data_read         = 1'b1;
    data_mem_address  = 32'h100;
    tick();
    checks++;
    if ({b_pmem_read, b_pmem_address} !== {1'b1, 32'h64}) begin
      errors++;
      $display("FAIL ifirst_slot1 got r%b a%h want r1 a64",
               b_pmem_read, b_pmem_address);
    end
    b_pmem_resp  = 1'b1;
    b_pmem_rdata = 32'hAAAA0001;
    tick();
    checks++;
    if ({b_pmem_read, b_pmem_address} !== {1'b1, 32'h100}) begin
      errors++;
      $display("FAIL ifirst_slot2 got r%b a%h want r1 a100",
               b_pmem_read, b_pmem_address);
    end
    b_pmem_rdata = 32'hBBBB0002;
    tick();
    b_pmem_resp = 1'b0;
    checks++;
    if ({b_instr_resp, b_data_resp, b_instr_rdata, b_data_rdata} !==
        {2'b11, 32'hAAAA0001, 32'hBBBB0002}) begin
      errors++;
      $display("FAIL ifirst_resp got %b%b %h %h want 11 aaaa0001 bbbb0002",
               b_instr_resp, b_data_resp, b_instr_rdata, b_data_rdata);
    end
    clear_inputs();
    tick();
    checks++;
    if ({b_instr_resp, b_data_resp, b_pmem_read} !== 3'b000) begin
      errors++;
      $display("FAIL ifirst_done got %b%b r%b want 0",
               b_instr_resp, b_data_resp, b_pmem_read);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_fetch_load();
    test_store();
    test_rw_both();
    test_mid_change();
    test_spurious();
    test_reset_mid();
    test_instr_first();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
